fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controls the front of the fetch stage. Every cycle it picks how many sequential instructions (0–4) to request from the instruction cache. The count is limited by instruction-buffer free slots, ROB free entries and icache readiness. The block drives the per-lane PCs to the icache and applies branch-unit redirects. It also allocates ROB indices, handing the decode stage a base ROB index (`fetch_rob_base`) that is aligned with each returned instruction group.

## Interface
Parameters:
- `FETCH_WIDTH`, 4, lanes per fetch group
- `PC_W`, 16, PC width; instructions are 2 bytes
- `ROB_IDX_W`, 4, ROB index width (16 entries)
- `RESET_PC`, 16'h0000, first fetch address

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `redirect_valid`  in  1  branch unit requests redirect
- `redirect_pc`  in  PC_W  redirect target
- `redirect_rob_idx`  in  ROB_IDX_W  ROB tail to resume allocation from
- `ibuf_free`  in  3  free instruction-buffer slots (0–7)
- `rob_free`  in  ROB_IDX_W+1  free ROB entries (0–16)
- `icache_ready`  in  1  icache can accept a request this cycle
- `icache_req_valid`  out  1  request issued this cycle
- `pc_to_icache[0:FETCH_WIDTH-1]`  out  PC_W each  lane PCs
- `lane_valid`  out  FETCH_WIDTH  per-lane request valid
- `fetch_valid`  out  1  icache data this cycle belongs to a live group
- `fetch_count`  out  3  valid lanes in the returned group (1–4)
- `fetch_rob_base`  out  ROB_IDX_W  ROB index of lane 0 of the returned group
- `squash`  out  1  pulse: an in-flight group was killed

## Operation
- Registered state:
  - `pc_q`: next fetch PC
  - `rob_tail_q`: next ROB index to allocate
  - `state`: one of IDLE, RUN, REDIRECT
  - response stage: `fetch_valid`, `fetch_count`, `fetch_rob_base`
- `grant = min(FETCH_WIDTH, ibuf_free, rob_free)`, computed combinationally.
- Issue condition: `state == RUN && icache_ready && grant != 0 && !redirect_valid`.
- On issue:
  - `icache_req_valid` = 1.
  - `lane_valid[i] = (i < grant)`.
  - `pc_to_icache[i] = pc_q + 2*i`, modulo 2^PC_W.
  - `pc_q <= pc_q + 2*grant`.
  - `rob_tail_q <= rob_tail_q + grant`, mod 16.
- When not issuing:
  - `icache_req_valid` = 0 and `lane_valid` = 0.
  - `pc_to_icache[i]` still shows `pc_q + 2*i`.
  - `pc_q` and `rob_tail_q` hold.
- States:
  - IDLE: entered on reset; no issue; moves to RUN on the next edge.
  - RUN: normal issue.
  - REDIRECT: one-cycle bubble after a redirect; no issue; then RUN.
- Redirect handling (`redirect_valid` = 1, any state):
  - `pc_q <= {redirect_pc[PC_W-1:1], 1'b0}`; bit 0 is forced to 0.
  - `rob_tail_q <= redirect_rob_idx`.
  - `state <= REDIRECT`.
  - Response stage is cleared: next-cycle `fetch_valid` = 0.
  - `squash` = 1 combinationally if the response stage currently holds a group (`fetch_valid` = 1).
- Redirect has priority over issue in the same cycle; that cycle's request is withheld.
- Redirect arriving while in REDIRECT: the new target wins and the bubble restarts.
- Stall sources (`ibuf_free` = 0, `rob_free` = 0, `icache_ready` = 0) only block issue. They never change `pc_q` or `rob_tail_q`.

## Timing
- Reset values (asynchronous):
  - `pc_q` = RESET_PC
  - `rob_tail_q` = 0
  - `state` = IDLE
  - `fetch_valid` = 0, `fetch_count` = 0, `fetch_rob_base` = 0
  - `icache_req_valid` = 0, `lane_valid` = 0, `squash` = 0
- First possible issue is the second rising edge after reset deasserts (IDLE, then RUN).
- Icache latency is 1 cycle. A request issued in cycle N yields `fetch_valid` = 1 in cycle N+1, with:
  - `fetch_count` = grant(N)
  - `fetch_rob_base` = `rob_tail_q`(N)
- Redirect in cycle N:
  - Cycle N+1: REDIRECT, no request.
  - Cycle N+2: first request from the target.
  - Redirect-to-first-fetch_valid is 3 cycles.
- Back-to-back issue every cycle is allowed; throughput is up to 4 instructions per cycle.
- Wrap-around: PC wraps mod 2^16 (lane PCs may straddle the wrap). ROB index wraps mod 16.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight data is dropped with no `squash` pulse.

## Structure
- Shared package `ooo_pkg`:
  - `FETCH_WIDTH`, `PC_W`, `ROB_IDX_W`
  - `INSTR_BYTES` = 2
  - fetch state enum {IDLE, RUN, REDIRECT}
- Sub-module `fetch_grant_calc`: combinational three-way minimum producing `grant` and `lane_valid`.
- Everything else lives in `fetch_sequencer`.

## Test plan
- Reset release, `ibuf_free`=7, `rob_free`=16, `icache_ready`=1 → first request at edge 2 with PCs 0,2,4,6 and `lane_valid`=4'b1111. Next cycle: `fetch_valid`=1, `fetch_count`=4, `fetch_rob_base`=0. Next request PCs 8,10,12,14, `rob_base` 4.
- `ibuf_free`=2, `rob_free`=16 → `lane_valid`=4'b0011, `pc_q` advances by 4, `rob_tail` by 2. Then `rob_free`=0 → no request, `pc_q` holds.
- Redirect to 16'h0101 with `redirect_rob_idx`=9 while a group is in flight → `squash`=1 that cycle, `fetch_valid`=0 next cycle, one bubble, then request PCs 0x100, 0x102, 0x104, 0x106 with `rob_base` 9.
- Redirect and issue conditions in the same cycle → no request issued; redirect path taken.
- `pc_q`=16'hFFFC, `rob_tail`=14, `grant`=4 → PCs FFFC, FFFE, 0000, 0002. Next `pc_q`=0004, `rob_tail`=2.
- `icache_ready`=0 for 3 cycles → no requests, state unchanged, resumes at the same PC. Reset asserted mid-run → outputs go to reset values with no clock edge required.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared front-end definitions for the out-of-order core.
// Holds fetch geometry constants and the fetch sequencer state encoding.
package ooo_pkg;

    localparam int unsigned FETCH_WIDTH = 4;
    localparam int unsigned PC_W        = 16;
    localparam int unsigned ROB_IDX_W   = 4;
    localparam int unsigned INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REDIRECT
    } fetch_state_e;

endpackage

// File: rtl/fetch_grant_calc.sv
// Fetch grant: min(FETCH_WIDTH, ibuf_free, rob_free) and the matching
// thermometer lane mask.
module fetch_grant_calc #(
    parameter int unsigned FETCH_WIDTH = ooo_pkg::FETCH_WIDTH,
    parameter int unsigned ROB_IDX_W   = ooo_pkg::ROB_IDX_W
) (
    input  logic [2:0]             ibuf_free,
    input  logic [ROB_IDX_W:0]     rob_free,
    output logic [2:0]             grant,
    output logic [FETCH_WIDTH-1:0] lane_valid
);

    logic [7:0] min_v;

    // Compare at a common 8-bit width so operand widths never truncate.
    always_comb begin
        min_v = 8'(FETCH_WIDTH);
        if (8'(ibuf_free) < min_v) min_v = 8'(ibuf_free);
        if (8'(rob_free) < min_v)  min_v = 8'(rob_free);
        grant = 3'(min_v);
    end

    always_comb begin
        lane_valid = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_valid[i] = (i < 32'(grant));
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-of-fetch sequencer: issues up to FETCH_WIDTH sequential lane PCs per
// cycle, allocates ROB indices and applies branch-unit redirects.
module fetch_sequencer #(
    parameter int unsigned         FETCH_WIDTH = ooo_pkg::FETCH_WIDTH,
    parameter int unsigned         PC_W        = ooo_pkg::PC_W,
    parameter int unsigned         ROB_IDX_W   = ooo_pkg::ROB_IDX_W,
    parameter logic [PC_W-1:0]     RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    input  logic [ROB_IDX_W-1:0]   redirect_rob_idx,
    input  logic [2:0]             ibuf_free,
    input  logic [ROB_IDX_W:0]     rob_free,
    input  logic                   icache_ready,
    output logic                   icache_req_valid,
    output logic [PC_W-1:0]        pc_to_icache [0:FETCH_WIDTH-1],
    output logic [FETCH_WIDTH-1:0] lane_valid,
    output logic                   fetch_valid,
    output logic [2:0]             fetch_count,
    output logic [ROB_IDX_W-1:0]   fetch_rob_base,
    output logic                   squash
);

    import ooo_pkg::*;

    fetch_state_e            state_q, state_d;
    logic [PC_W-1:0]         pc_q;
    logic [ROB_IDX_W-1:0]    rob_tail_q;
    logic [2:0]              grant;
    logic [FETCH_WIDTH-1:0]  grant_lanes;
    logic                    issue;

    fetch_grant_calc #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .ROB_IDX_W   (ROB_IDX_W)
    ) u_grant (
        .ibuf_free  (ibuf_free),
        .rob_free   (rob_free),
        .grant      (grant),
        .lane_valid (grant_lanes)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = RUN;
            RUN:      state_d = RUN;
            REDIRECT: state_d = RUN;
            default:  state_d = IDLE;
        endcase
        if (redirect_valid) state_d = REDIRECT;
    end

    // Redirect has priority: it withholds any request in its own cycle.
    always_comb begin
        issue            = (state_q == RUN) && icache_ready && (grant != '0) && !redirect_valid;
        icache_req_valid = issue;
        lane_valid       = issue ? grant_lanes : '0;
        squash           = redirect_valid && fetch_valid;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            pc_to_icache[i] = pc_q + PC_W'(i * INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rob_tail_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[PC_W-1:1], 1'b0};
            rob_tail_q <= redirect_rob_idx;
        end else if (issue) begin
            pc_q       <= pc_q + PC_W'(INSTR_BYTES * 32'(grant));
            rob_tail_q <= rob_tail_q + ROB_IDX_W'(grant);
        end
    end

    // Response stage mirrors the one-cycle icache latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid    <= 1'b0;
            fetch_count    <= '0;
            fetch_rob_base <= '0;
        end else if (redirect_valid) begin
            fetch_valid    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            fetch_valid    <= issue;
            fetch_count    <= issue ? grant : '0;
            if (issue) fetch_rob_base <= rob_tail_q;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [3:0]  redirect_rob_idx = '0;
    logic [2:0]  ibuf_free = 3'd7;
    logic [4:0]  rob_free = 5'd16;
    logic        icache_ready = 1'b1;
    logic        icache_req_valid;
    logic [15:0] pc_to_icache [0:3];
    logic [3:0]  lane_valid;
    logic        fetch_valid;
    logic [2:0]  fetch_count;
    logic [3:0]  fetch_rob_base;
    logic        squash;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .FETCH_WIDTH (4),
        .PC_W        (16),
        .ROB_IDX_W   (4),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_rob_idx (redirect_rob_idx),
        .ibuf_free        (ibuf_free),
        .rob_free         (rob_free),
        .icache_ready     (icache_ready),
        .icache_req_valid (icache_req_valid),
        .pc_to_icache     (pc_to_icache),
        .lane_valid       (lane_valid),
        .fetch_valid      (fetch_valid),
        .fetch_count      (fetch_count),
        .fetch_rob_base   (fetch_rob_base),
        .squash           (squash)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then applied
    // and outputs sampled 1 time unit later, well away from either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_req",   32'(icache_req_valid), 32'd0);
        check("rst_lanes", 32'(lane_valid),       32'd0);
        check("rst_fv",    32'(fetch_valid),      32'd0);
        check("rst_cnt",   32'(fetch_count),      32'd0);
        check("rst_base",  32'(fetch_rob_base),   32'd0);
        check("rst_pc0",   32'(pc_to_icache[0]),  32'h0000);
        check("rst_sq",    32'(squash),           32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        // IDLE cycle
        check("idle_req", 32'(icache_req_valid), 32'd0);

        next_cycle(); #1;  // RUN: first request
        check("b_req",   32'(icache_req_valid), 32'd1);
        check("b_lanes", 32'(lane_valid),       32'hF);
        check("b_pc0",   32'(pc_to_icache[0]),  32'h0000);
        check("b_pc1",   32'(pc_to_icache[1]),  32'h0002);
        check("b_pc2",   32'(pc_to_icache[2]),  32'h0004);
        check("b_pc3",   32'(pc_to_icache[3]),  32'h0006);

        next_cycle(); #1;
        check("c_fv",    32'(fetch_valid),      32'd1);
        check("c_cnt",   32'(fetch_count),      32'd4);
        check("c_base",  32'(fetch_rob_base),   32'd0);
        check("c_pc0",   32'(pc_to_icache[0]),  32'h0008);
        check("c_pc3",   32'(pc_to_icache[3]),  32'h000E);
        check("c_req",   32'(icache_req_valid), 32'd1);

        next_cycle(); ibuf_free = 3'd2; #1;
        check("d_base",  32'(fetch_rob_base),   32'd4);
        check("d_lanes", 32'(lane_valid),       32'b0011);
        check("d_pc0",   32'(pc_to_icache[0]),  32'h0010);

        next_cycle(); ibuf_free = 3'd7; rob_free = 5'd0; #1;
        check("e_cnt",   32'(fetch_count),      32'd2);
        check("e_base",  32'(fetch_rob_base),   32'd8);
        check("e_req",   32'(icache_req_valid), 32'd0);
        check("e_lanes", 32'(lane_valid),       32'd0);
        check("e_pc0",   32'(pc_to_icache[0]),  32'h0014);

        next_cycle(); rob_free = 5'd16; #1;
        check("f_fv",    32'(fetch_valid),      32'd0);
        check("f_pc0",   32'(pc_to_icache[0]),  32'h0014);
        check("f_req",   32'(icache_req_valid), 32'd1);

        // redirect while a group is in flight, with issue otherwise possible
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'h0101; redirect_rob_idx = 4'd9; #1;
        check("g_fv",    32'(fetch_valid),      32'd1);
        check("g_base",  32'(fetch_rob_base),   32'd10);
        check("g_sq",    32'(squash),           32'd1);
        check("g_req",   32'(icache_req_valid), 32'd0);
        check("g_lanes", 32'(lane_valid),       32'd0);

        next_cycle(); redirect_valid = 1'b0; #1;
        check("h_fv",    32'(fetch_valid),      32'd0);
        check("h_sq",    32'(squash),           32'd0);
        check("h_req",   32'(icache_req_valid), 32'd0);
        check("h_pc0",   32'(pc_to_icache[0]),  32'h0100);

        next_cycle(); #1;
        check("i_req",   32'(icache_req_valid), 32'd1);
        check("i_pc0",   32'(pc_to_icache[0]),  32'h0100);
        check("i_pc1",   32'(pc_to_icache[1]),  32'h0102);
        check("i_pc2",   32'(pc_to_icache[2]),  32'h0104);
        check("i_pc3",   32'(pc_to_icache[3]),  32'h0106);

        next_cycle(); redirect_valid = 1'b1; redirect_pc = 16'h0200; redirect_rob_idx = 4'd3; #1;
        check("j_fv",    32'(fetch_valid),      32'd1);
        check("j_cnt",   32'(fetch_count),      32'd4);
        check("j_base",  32'(fetch_rob_base),   32'd9);
        check("j_sq",    32'(squash),           32'd1);

        // second redirect during the bubble: new target wins
        next_cycle(); redirect_pc = 16'hFFFD; redirect_rob_idx = 4'd14; #1;
        check("k_sq",    32'(squash),           32'd0);
        check("k_req",   32'(icache_req_valid), 32'd0);
        check("k_pc0",   32'(pc_to_icache[0]),  32'h0200);

        next_cycle(); redirect_valid = 1'b0; #1;
        check("l_req",   32'(icache_req_valid), 32'd0);
        check("l_pc0",   32'(pc_to_icache[0]),  32'hFFFC);

        next_cycle(); #1;
        check("m_req",   32'(icache_req_valid), 32'd1);
        check("m_pc0",   32'(pc_to_icache[0]),  32'hFFFC);
        check("m_pc1",   32'(pc_to_icache[1]),  32'hFFFE);
        check("m_pc2",   32'(pc_to_icache[2]),  32'h0000);
        check("m_pc3",   32'(pc_to_icache[3]),  32'h0002);

        next_cycle(); icache_ready = 1'b0; #1;
        check("n_fv",    32'(fetch_valid),      32'd1);
        check("n_base",  32'(fetch_rob_base),   32'd14);
        check("n_req",   32'(icache_req_valid), 32'd0);
        check("n_pc0",   32'(pc_to_icache[0]),  32'h0004);

        next_cycle(); #1;
        check("o_fv",    32'(fetch_valid),      32'd0);
        check("o_req",   32'(icache_req_valid), 32'd0);

        next_cycle(); #1;
        check("p_req",   32'(icache_req_valid), 32'd0);
        check("p_pc0",   32'(pc_to_icache[0]),  32'h0004);

        next_cycle(); icache_ready = 1'b1; #1;
        check("q_req",   32'(icache_req_valid), 32'd1);
        check("q_pc0",   32'(pc_to_icache[0]),  32'h0004);
        check("q_pc1",   32'(pc_to_icache[1]),  32'h0006);

        next_cycle(); #1;
        check("r_fv",    32'(fetch_valid),      32'd1);
        check("r_base",  32'(fetch_rob_base),   32'd2);
        check("r_pc0",   32'(pc_to_icache[0]),  32'h000C);

        // asynchronous reset mid-run, sampled before any further edge
        rst = 1'b1;
        #1;
        check("ar_fv",    32'(fetch_valid),      32'd0);
        check("ar_cnt",   32'(fetch_count),      32'd0);
        check("ar_base",  32'(fetch_rob_base),   32'd0);
        check("ar_req",   32'(icache_req_valid), 32'd0);
        check("ar_lanes", 32'(lane_valid),       32'd0);
        check("ar_sq",    32'(squash),           32'd0);
        check("ar_pc0",   32'(pc_to_icache[0]),  32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
